// File: rtl/bomb_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bomb_game_ctrl_if : game controls, puzzle status and countdown link  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface bomb_game_ctrl_if #(
  parameter int NUM_MODULES = 3
);
  logic                   start_btn;
  logic                   pause_btn;
  logic [11:0]            cfg_time;
  logic [NUM_MODULES-1:0] solved;
  logic [NUM_MODULES-1:0] strike;
  logic                   timer_expired;
  logic [11:0]            init_time;
  logic                   timer_rst_n;
  logic                   timer_toggle;
  logic                   sec_tick;
  logic [1:0]             strikes;
  logic [2:0]             state;
  logic                   win;
  logic                   lose;

  // master = game environment (buttons, puzzles, countdown); slave = sequencer
  modport master (
    output start_btn, pause_btn, cfg_time, solved, strike, timer_expired,
    input  init_time, timer_rst_n, timer_toggle, sec_tick, strikes, state, win, lose
  );

  modport slave (
    input  start_btn, pause_btn, cfg_time, solved, strike, timer_expired,
    output init_time, timer_rst_n, timer_toggle, sec_tick, strikes, state, win, lose
  );
endinterface
`default_nettype wire

// File: rtl/bomb_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bomb_game_ctrl : game sequencer, strike counter and seconds prescaler|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bomb_game_ctrl #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int NUM_MODULES = 3,
  parameter int MAX_STRIKES = 3
) (
  input  logic             clk,
  input  logic             reset,
  bomb_game_ctrl_if.slave  bus
);

  localparam int         CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] C_MAX_S = 2'(MAX_STRIKES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_START    = 3'd2,
    S_RUNNING  = 3'd3,
    S_PAUSED   = 3'd4,
    S_DEFUSED  = 3'd5,
    S_EXPLODED = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        init_time_q, init_time_d;
  logic [1:0]         strikes_q, strikes_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timer_rst_n_q, timer_rst_n_d;
  logic               timer_toggle_q, timer_toggle_d;
  logic               sec_tick_q, sec_tick_d;
  logic               win_q, win_d;
  logic               lose_q, lose_d;

  logic [NUM_MODULES-1:0] strike_eff;
  logic [7:0]             strike_new;
  logic [8:0]             strike_sum;
  logic                   strike_out;
  logic [31:0]            period;
  logic [CNT_W-1:0]       period_m1;

  function automatic logic [11:0] clamp_bcd(input logic [11:0] t);
    logic [11:0] r;
    r = t;
    for (int i = 0; i < 3; i++) begin
      if (t[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  always_comb begin
    state_d        = state_q;
    init_time_d    = init_time_q;
    strikes_d      = strikes_q;
    cnt_d          = cnt_q;
    timer_toggle_d = 1'b0;
    sec_tick_d     = 1'b0;

    // Strikes on an already-solved module do not count
    strike_eff = bus.strike & ~bus.solved;
    strike_new = 8'd0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      strike_new = strike_new + 8'(strike_eff[i]);
    end
    strike_sum = 9'(strikes_q) + 9'(strike_new);
    strike_out = (strike_sum >= 9'(MAX_STRIKES));

    case (state_q)
      S_IDLE, S_DEFUSED, S_EXPLODED: begin
        if (bus.start_btn) begin
          state_d     = S_LOAD;
          init_time_d = clamp_bcd(bus.cfg_time);
          strikes_d   = 2'd0;
        end
      end
      S_LOAD: begin
        state_d        = S_START;
        timer_toggle_d = 1'b1;
      end
      S_START: begin
        state_d = S_RUNNING;
      end
      S_RUNNING: begin
        strikes_d = strike_out ? C_MAX_S : strike_sum[1:0];
        // Losing beats winning and pausing; the display freezes on its own
        if (bus.timer_expired || strike_out) begin
          state_d = S_EXPLODED;
        end else if (&bus.solved) begin
          state_d        = S_DEFUSED;
          timer_toggle_d = 1'b1;
        end else if (bus.pause_btn) begin
          state_d        = S_PAUSED;
          timer_toggle_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (bus.pause_btn) begin
          state_d        = S_RUNNING;
          timer_toggle_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    period    = 32'(TICK_DIV) >> strikes_d;
    period_m1 = CNT_W'(period - 32'd1);

    if (strikes_d != strikes_q) begin
      cnt_d = '0;
    end else if (state_q == S_RUNNING && state_d == S_RUNNING) begin
      if (cnt_q == period_m1) begin
        cnt_d      = '0;
        sec_tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (state_q == S_PAUSED || (state_q == S_RUNNING && state_d == S_PAUSED)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = '0;
    end

    timer_rst_n_d = !(state_d == S_IDLE || state_d == S_LOAD);
    win_d         = (state_d == S_DEFUSED);
    lose_d        = (state_d == S_EXPLODED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      init_time_q    <= 12'd0;
      strikes_q      <= 2'd0;
      cnt_q          <= '0;
      timer_rst_n_q  <= 1'b0;
      timer_toggle_q <= 1'b0;
      sec_tick_q     <= 1'b0;
      win_q          <= 1'b0;
      lose_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_time_q    <= init_time_d;
      strikes_q      <= strikes_d;
      cnt_q          <= cnt_d;
      timer_rst_n_q  <= timer_rst_n_d;
      timer_toggle_q <= timer_toggle_d;
      sec_tick_q     <= sec_tick_d;
      win_q          <= win_d;
      lose_q         <= lose_d;
    end
  end

  assign bus.init_time    = init_time_q;
  assign bus.timer_rst_n  = timer_rst_n_q;
  assign bus.timer_toggle = timer_toggle_q;
  assign bus.sec_tick     = sec_tick_q;
  assign bus.strikes      = strikes_q;
  assign bus.state        = state_q;
  assign bus.win          = win_q;
  assign bus.lose         = lose_q;

endmodule
`default_nettype wire

// File: tb/tb_bomb_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bomb_game_ctrl : directed self-checking bench, TICK_DIV=8         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_bomb_game_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_tog;
  int   n_tick;

  bomb_game_ctrl_if #(.NUM_MODULES(3)) bus ();

  bomb_game_ctrl #(
    .TICK_DIV    (8),
    .NUM_MODULES (3),
    .MAX_STRIKES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [11:0] cfg);
    bus.cfg_time  = cfg;
    bus.start_btn = 1'b1;
    step();
    bus.start_btn = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.start_btn     = 1'b0;
    bus.pause_btn     = 1'b0;
    bus.cfg_time      = 12'h000;
    bus.solved        = 3'b000;
    bus.strike        = 3'b000;
    bus.timer_expired = 1'b0;
    step();
    step();
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_rst_n", 32'(bus.timer_rst_n), 0);
    chk("rst_toggle", 32'(bus.timer_toggle), 0);
    chk("rst_tick", 32'(bus.sec_tick), 0);
    chk("rst_init", 32'(bus.init_time), 0);
    chk("rst_winlose", 32'({bus.win, bus.lose, bus.strikes}), 0);
    reset = 1'b0;
    step();

    // Start with clamp, load, toggle, then 8-cycle ticks
    start_game(12'h0A5);
    chk("t1_load_state", 32'(bus.state), 1);
    chk("t1_load_rst_n", 32'(bus.timer_rst_n), 0);
    chk("t1_init_time", 32'(bus.init_time), 32'h095);
    step();
    chk("t1_start_state", 32'(bus.state), 2);
    chk("t1_start_toggle", 32'(bus.timer_toggle), 1);
    chk("t1_start_rst_n", 32'(bus.timer_rst_n), 1);
    step();
    chk("t1_run_state", 32'(bus.state), 3);
    chk("t1_run_toggle", 32'(bus.timer_toggle), 0);
    for (int k = 1; k <= 15; k++) begin
      step();
      chk($sformatf("t1_tick%0d", k), 32'(bus.sec_tick), 32'(k % 8 == 0));
    end

    // Strike lands on the edge where a tick was due
    bus.strike = 3'b001;
    step();
    bus.strike = 3'b000;
    chk("t2_strikes1", 32'(bus.strikes), 1);
    chk("t2_tick_suppr", 32'(bus.sec_tick), 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("t2_tick%0d", k), 32'(bus.sec_tick), 32'(k % 4 == 0));
    end
    bus.strike = 3'b110;
    step();
    bus.strike = 3'b000;
    chk("t2_strikes3", 32'(bus.strikes), 3);
    chk("t2_exploded", 32'(bus.state), 6);
    chk("t2_lose", 32'(bus.lose), 1);
    chk("t2_no_toggle", 32'(bus.timer_toggle), 0);

    // Restart with full clamp, pause after 5 counts
    start_game(12'hFFF);
    chk("t3_load_state", 32'(bus.state), 1);
    chk("t3_init_time", 32'(bus.init_time), 32'h999);
    chk("t3_strikes_clr", 32'(bus.strikes), 0);
    chk("t3_lose_clr", 32'(bus.lose), 0);
    step();
    step();
    chk("t3_run_state", 32'(bus.state), 3);
    for (int k = 1; k <= 5; k++) begin
      bus.start_btn = (k == 3);
      step();
    end
    bus.start_btn = 1'b0;
    chk("t3_start_ignored", 32'(bus.state), 3);
    bus.pause_btn = 1'b1;
    step();
    bus.pause_btn = 1'b0;
    chk("t3_paused", 32'(bus.state), 4);
    chk("t3_pause_toggle", 32'(bus.timer_toggle), 1);
    chk("t3_pause_tick", 32'(bus.sec_tick), 0);
    n_tog  = 0;
    n_tick = 0;
    for (int k = 1; k <= 20; k++) begin
      bus.timer_expired = (k <= 10);
      bus.strike        = (k == 5) ? 3'b001 : 3'b000;
      step();
      n_tog  += int'(bus.timer_toggle);
      n_tick += int'(bus.sec_tick);
      chk($sformatf("t3_hold%0d", k), 32'(bus.state), 4);
    end
    bus.timer_expired = 1'b0;
    bus.strike        = 3'b000;
    chk("t3_pause_togs", 32'(n_tog), 0);
    chk("t3_pause_ticks", 32'(n_tick), 0);
    chk("t3_pause_strikes", 32'(bus.strikes), 0);
    bus.pause_btn = 1'b1;
    step();
    bus.pause_btn = 1'b0;
    chk("t3_resumed", 32'(bus.state), 3);
    chk("t3_resume_toggle", 32'(bus.timer_toggle), 1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("t3_rtick%0d", k), 32'(bus.sec_tick), 32'(k == 3));
    end

    // Strike on a solved module is ignored; then defuse and restart
    bus.solved = 3'b001;
    bus.strike = 3'b001;
    step();
    chk("t4_solved_strike", 32'(bus.strikes), 0);
    bus.strike = 3'b010;
    step();
    bus.strike = 3'b000;
    chk("t4_strike", 32'(bus.strikes), 1);
    bus.solved = 3'b111;
    step();
    chk("t4_defused", 32'(bus.state), 5);
    chk("t4_win", 32'(bus.win), 1);
    chk("t4_toggle", 32'(bus.timer_toggle), 1);
    step();
    chk("t4_toggle_once", 32'(bus.timer_toggle), 0);
    bus.solved = 3'b000;
    start_game(12'h321);
    chk("t4_load_state", 32'(bus.state), 1);
    chk("t4_strikes_clr", 32'(bus.strikes), 0);
    chk("t4_win_clr", 32'(bus.win), 0);
    step();
    step();

    // Expiry beats all-solved in the same cycle
    bus.solved        = 3'b111;
    bus.timer_expired = 1'b1;
    step();
    bus.solved        = 3'b000;
    bus.timer_expired = 1'b0;
    chk("t5_exp_vs_solved", 32'(bus.state), 6);
    chk("t5_no_toggle", 32'(bus.timer_toggle), 0);
    chk("t5_lose", 32'(bus.lose), 1);

    // Expiry beats pause in the same cycle
    start_game(12'h010);
    step();
    step();
    bus.pause_btn     = 1'b1;
    bus.timer_expired = 1'b1;
    step();
    bus.pause_btn     = 1'b0;
    bus.timer_expired = 1'b0;
    chk("t5_exp_vs_pause", 32'(bus.state), 6);
    chk("t5_pause_no_tog", 32'(bus.timer_toggle), 0);

    // Reset while the start toggle is high
    start_game(12'h045);
    step();
    chk("t6_start_toggle", 32'(bus.timer_toggle), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_idle", 32'(bus.state), 0);
    chk("t6_toggle_cut", 32'(bus.timer_toggle), 0);
    chk("t6_rst_n", 32'(bus.timer_rst_n), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
